// File: rtl/hazard_stall_unit.sv
// Load-use interlock and control-hazard flush unit for a 5-stage pipeline.
// Also holds the pipeline in a HALTED state between a halt and a go pulse.
module hazard_stall_unit #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_ra,
   input  logic [4:0]       id_rb,
   input  logic             id_ra_used,
   input  logic             id_rb_used,
   input  logic [4:0]       ex_dst,
   input  logic             ex_memtoreg,
   input  logic             ex_branch_taken,
   input  logic             halt,
   input  logic             go,
   output logic             stall_pc,
   output logic             stall_ifid,
   output logic             flush_ifid,
   output logic             flush_idex,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {StRun, StStall1, StHalted} state_e;

   state_e state_q;
   logic   hit;
   logic   stall_evt;
   logic   flush_evt;

   assign hit = ex_memtoreg && (ex_dst != 5'd0) &&
                ((id_ra_used && (id_ra == ex_dst)) || (id_rb_used && (id_rb == ex_dst)));

   // Branch beats a load-use hit; halt never changes this cycle's outputs.
   always_comb begin
      stall_evt = 1'b0;
      flush_evt = 1'b0;
      unique case (state_q)
         StRun: begin
            flush_evt = ex_branch_taken;
            stall_evt = hit && !ex_branch_taken;
         end
         StStall1: begin
            flush_evt = ex_branch_taken;
            stall_evt = !ex_branch_taken;
         end
         default: ;
      endcase
   end

   always_comb begin
      stall_pc   = stall_evt;
      stall_ifid = stall_evt;
      flush_ifid = flush_evt;
      flush_idex = stall_evt || flush_evt;
      halted     = 1'b0;
      if (state_q == StHalted) begin
         stall_pc   = 1'b1;
         stall_ifid = 1'b1;
         flush_idex = 1'b1;
         halted     = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StRun;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         unique case (state_q)
            StHalted: if (go) state_q <= StRun;
            default: begin
               if (halt)                                 state_q <= StHalted;
               else if (ex_branch_taken)                 state_q <= StRun;
               else if (state_q == StRun && hit)         state_q <= StStall1;
               else                                      state_q <= StRun;
            end
         endcase
         if (stall_evt && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
         if (flush_evt && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
      end
   end

endmodule

// File: doc/hazard_stall_unit.md
HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the stall and flush statistics counters.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port id_ra  input  5  ID-stage source register A.
REQ-005 SHALL have port id_rb  input  5  ID-stage source register B.
REQ-006 SHALL have port id_ra_used  input  1  ID instruction reads ra.
REQ-007 SHALL have port id_rb_used  input  1  ID instruction reads rb.
REQ-008 SHALL have port ex_dst  input  5  EX-stage destination register.
REQ-009 SHALL have port ex_memtoreg  input  1  EX instruction is a load.
REQ-010 SHALL have port ex_branch_taken  input  1  EX resolved taken branch or jump.
REQ-011 SHALL have port halt  input  1  syscall/halt reached EX.
REQ-012 SHALL have port go  input  1  resume pulse from HALTED.
REQ-013 SHALL have port stall_pc  output  1  hold PC.
REQ-014 SHALL have port stall_ifid  output  1  hold IF/ID register.
REQ-015 SHALL have port flush_ifid  output  1  clear IF/ID to bubble.
REQ-016 SHALL have port flush_idex  output  1  clear ID/EX to bubble.
REQ-017 SHALL have port halted  output  1  FSM in HALTED.
REQ-018 SHALL have port stall_cnt  output  CNT_W  cycles with stall_pc asserted by a load-use interlock.
REQ-019 SHALL have port flush_cnt  output  CNT_W  branch flush events.

Function
REQ-020 Hazard hit SHALL be (ex_memtoreg & ex_dst!=0 & ((id_ra_used & id_ra==ex_dst) | (id_rb_used & id_rb==ex_dst))).
REQ-021 Loaded data reaches the forwarding network only from WB; every load-use SHALL therefore cost exactly 2 stall cycles.
REQ-022 FSM states SHALL be RUN, STALL1, HALTED.
REQ-023 RUN with hit and no branch/halt: stall_pc=stall_ifid=flush_idex=1 combinationally this cycle; next state STALL1.
REQ-024 STALL1: stall_pc=stall_ifid=flush_idex=1 unconditionally; next state RUN (hit is not re-evaluated).
REQ-025 ex_branch_taken in RUN or STALL1: flush_ifid=flush_idex=1, stall_pc=stall_ifid=0, next state RUN; branch overrides a simultaneous hit.
REQ-026 halt in RUN or STALL1: next state HALTED; halt has priority over branch and hit; outputs that cycle follow REQ-023..025 as if halt were 0.
REQ-027 HALTED: stall_pc=stall_ifid=1, flush_idex=1, flush_ifid=0, halted=1; go=1 returns to RUN next edge; halt ignored while HALTED.
REQ-028 Outside REQ-023..027 all control outputs SHALL be 0.
REQ-029 stall_cnt SHALL increment by 1 each cycle REQ-023 or REQ-024 applies; HALTED cycles not counted.
REQ-030 flush_cnt SHALL increment by 1 each cycle REQ-025 applies.
REQ-031 Both counters SHALL saturate at 2^CNT_W-1, never wrap.
REQ-032 ex_dst==0 loads SHALL never stall.

Reset
REQ-033 rst_n low SHALL immediately force state RUN, stall_cnt=0, flush_cnt=0, halted=0, independent of clk.
REQ-034 Reset asserted in STALL1 or HALTED SHALL abandon it; first cycle after release behaves as RUN.
REQ-035 Control outputs during reset SHALL be purely the RUN combinational decode of current inputs.

Verification
REQ-036 Load r5 in EX, ID reads ra=5 used -> stall 2 cycles (t0,t1), t2 no stall, stall_cnt=2.
REQ-037 Load r0 in EX, ID reads r0 -> no stall, stall_cnt=0; load r5 with id_ra_used=0, id_rb=5 used -> stall 2.
REQ-038 Hit and ex_branch_taken same cycle -> flush_ifid=flush_idex=1, stall_pc=0, next cycle RUN, flush_cnt=1, stall_cnt=0.
REQ-039 halt pulse -> halted=1 from next cycle, stall_pc held for 10 cycles, go pulse -> RUN, halted=0.
REQ-040 CNT_W=4, 9 back-to-back load-use hazards -> stall_cnt stops at 15.
REQ-041 rst_n low mid STALL1 -> counters 0 asynchronously, after release no residual stall cycle.
